// File: rtl/pc_logic.sv
// Program counter with PC+4 / PC+8 adders and PC-source select.
// PCS is purely combinational from Rd/Branch/RegW; the PC register is the only state.
module pc_logic #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Rd,
    input  logic        Branch,
    input  logic        RegW,
    input  logic        PCEn,
    input  logic [31:0] Result,
    output logic        PCS,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCPlus8
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // A write to R15 redirects the PC just like a taken branch.
    assign PCS     = Branch | (RegW & (Rd == 4'd15));
    assign PCPlus4 = pc_q + 32'd4;
    assign PCPlus8 = pc_q + 32'd8;
    assign PC      = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (PCEn) begin
            pc_d = PCS ? Result : PCPlus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_logic.sv
// Directed self-checking bench for pc_logic: PCS truth table, exhaustive sweep,
// and sequential fetch / branch / stall / reset / wrap sequences.
module tb_pc_logic;

    logic        clk;
    logic        reset;
    logic [3:0]  Rd;
    logic        Branch;
    logic        RegW;
    logic        PCEn;
    logic [31:0] Result;
    logic        PCS;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] PCPlus8;

    int checks;
    int failures;

    pc_logic #(.RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .reset   (reset),
        .Rd      (Rd),
        .Branch  (Branch),
        .RegW    (RegW),
        .PCEn    (PCEn),
        .Result  (Result),
        .PCS     (PCS),
        .PC      (PC),
        .PCPlus4 (PCPlus4),
        .PCPlus8 (PCPlus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rd;
        logic       br;
        logic       rw;
        logic       exp_pcs;
    } pcs_vec_t;

    pcs_vec_t vecs [8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset  = 1'b1;
        Rd     = 4'd0;
        Branch = 1'b0;
        RegW   = 1'b0;
        PCEn   = 1'b0;
        Result = 32'h0;

        vecs[0] = '{4'd4,  1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'd4,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'd15, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{4'd4,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd15, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'd14, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'd0,  1'b1, 1'b1, 1'b1};
        vecs[7] = '{4'd15, 1'b1, 1'b1, 1'b1};

        // Truth table with 100 ns holds
        for (int i = 0; i < 8; i++) begin
            Rd     = vecs[i].rd;
            Branch = vecs[i].br;
            RegW   = vecs[i].rw;
            #100;
            check1($sformatf("pcs_vec%0d", i), PCS, vecs[i].exp_pcs);
        end

        // Exhaustive sweep; only mismatches are reported individually
        begin
            int sweep_bad;
            sweep_bad = 0;
            for (int i = 0; i < 64; i++) begin
                logic [5:0] c;
                logic       e;
                c      = i[5:0];
                Rd     = c[3:0];
                Branch = c[4];
                RegW   = c[5];
                e      = (c[3:0] == 4'hF && c[5]) || c[4];
                #1;
                checks++;
                if (PCS !== e) begin
                    failures++;
                    sweep_bad++;
                    $display("FAIL pcs_sweep rd=%0d br=%b rw=%b: got %b expected %b",
                             c[3:0], c[4], c[5], PCS, e);
                end
            end
            $display("sweep: 64 combinations, %0d bad", sweep_bad);
        end

        // Reset: PC loads RESET_PC; PCS still follows its inputs during reset
        Rd = 4'd0; RegW = 1'b0; Branch = 1'b1; PCEn = 1'b1; Result = 32'hDEAD_BEEF;
        reset = 1'b1;
        tick();
        check32("reset_pc", PC, 32'h0);
        check1("pcs_in_reset", PCS, 1'b1);
        check32("reset_pcplus4", PCPlus4, 32'h4);
        check32("reset_pcplus8", PCPlus8, 32'h8);

        // Sequential fetch
        Branch = 1'b0;
        reset  = 1'b0;
        tick(); check32("fetch1", PC, 32'd4);
        tick(); check32("fetch2", PC, 32'd8);
        // Branch redirect from PC=8
        Branch = 1'b1; Result = 32'h0000_0100;
        tick(); check32("branch_target", PC, 32'h100);
        Branch = 1'b0;
        tick(); check32("after_branch", PC, 32'h104);

        // Re-run fetch to observe PC=12 and PCPlus8=20
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick(); tick();
        check32("fetch3", PC, 32'd12);
        check32("fetch3_plus8", PCPlus8, 32'd20);

        // R15 write redirects, other registers do not
        RegW = 1'b1; Rd = 4'd15; Result = 32'h0000_2000;
        tick(); check32("r15_write", PC, 32'h2000);
        Rd = 4'd14; Result = 32'h0000_9999;
        tick(); check32("r14_write", PC, 32'h2004);
        RegW = 1'b0;

        // X on PCEn/Result must not reach PCS
        PCEn = 1'bx; Result = 32'hxxxx_xxxx; Branch = 1'b0; Rd = 4'd15;
        #1; check1("pcs_x_isolation", PCS, 1'b0);

        // Stall with Branch asserted, then reset overrides everything
        PCEn = 1'b0; Branch = 1'b1; Result = 32'h0000_DEAD;
        tick(); check32("stall_hold", PC, 32'h2004);
        reset = 1'b1; PCEn = 1'b1;
        tick(); check32("reset_over_branch", PC, 32'h0);
        reset = 1'b0;

        // Unaligned Result is loaded unmodified
        Result = 32'h0000_0003;
        tick(); check32("no_align_mask", PC, 32'h3);

        // Wrap-around
        Result = 32'hFFFF_FFFC;
        tick();
        check32("wrap_load", PC, 32'hFFFF_FFFC);
        check32("wrap_plus4", PCPlus4, 32'h0);
        check32("wrap_plus8", PCPlus8, 32'h4);
        Branch = 1'b0;
        tick(); check32("wrap_pc", PC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_logic.md
PC_LOGIC -- requirements
Module: pc_logic

Interface
REQ-001 Clock and reset: one clock, clk; reset is synchronous and active-high, reset.
REQ-002 Port: clk, input, 1, rising-edge clock for all state.
REQ-003 Port: reset, input, 1, synchronous active-high reset, sampled only at the rising edge of clk.
REQ-004 Port: Rd, input, 4, destination register index of the current instruction.
REQ-005 Port: Branch, input, 1, branch instruction is executing.
REQ-006 Port: RegW, input, 1, register write enable of the current instruction.
REQ-007 Port: PCEn, input, 1, PC update enable; active-high.
REQ-008 Port: Result, input, 32, next-PC value used when PCS=1, such as a branch target or an R15 write value.
REQ-009 Port: PCS, output, 1, PC source select; 1 selects Result, 0 selects PC+4.
REQ-010 Port: PC, output, 32, current program counter (registered).
REQ-011 Port: PCPlus4, output, 32, PC+4.
REQ-012 Port: PCPlus8, output, 32, PC+8, which is the R15 read value.
REQ-013 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.

Function
REQ-014 PCS SHALL be purely combinational: PCS = Branch OR (RegW AND (Rd == 4'd15)).
REQ-015 PCS SHALL depend only on Rd, Branch and RegW, and SHALL NOT depend on clk, reset, PCEn, Result or PC.
REQ-016 PCS SHALL settle within the same evaluation as its inputs change; it has zero-cycle latency and no registers in its path.
REQ-017 Rd values 0-14 SHALL never assert PCS by themselves; only Rd=15 together with RegW=1 does.
REQ-018 Branch=1 SHALL assert PCS regardless of Rd and RegW.
REQ-019 PCPlus4 SHALL be PC+4 and PCPlus8 SHALL be PC+8, both combinational.
REQ-020 Both sums SHALL be modulo 2^32 and wrap silently; for example, PC=32'hFFFF_FFFC gives PCPlus4=0 and PCPlus8=4.
REQ-021 At a rising edge with reset=0 and PCEn=1, PC SHALL load Result if PCS=1, else PCPlus4.
REQ-022 At a rising edge with reset=0 and PCEn=0, PC SHALL hold its value, even if PCS=1.
REQ-023 Result SHALL be loaded unmodified; there is no alignment masking.
REQ-024 X or Z on PCEn or Result SHALL NOT propagate to PCS.
REQ-025 The block SHALL contain no state other than the PC register.

Reset
REQ-026 At a rising edge with reset=1, PC SHALL load RESET_PC, overriding PCEn, PCS and Result.
REQ-027 After reset, PCPlus4 SHALL equal RESET_PC+4 and PCPlus8 SHALL equal RESET_PC+8.
REQ-028 PCS SHALL be unaffected by reset and SHALL follow REQ-014 while reset is asserted.
REQ-029 Reset asserted mid-operation SHALL take effect at the next rising edge; there is no asynchronous behaviour.

Verification
REQ-030 PCS truth table, combinational, with 100 ns holds:
- Rd=4, Branch=0, RegW=1 -> PCS=0
- Rd=4, Branch=1, RegW=0 -> PCS=1
- Rd=15, Branch=0, RegW=1 -> PCS=1
- Rd=4, Branch=0, RegW=0 -> PCS=0
REQ-031 Exhaustive sweep: all 64 combinations of Rd, Branch and RegW -> PCS matches REQ-014; Rd=15 with RegW=0 and Branch=0 -> PCS=0.
REQ-032 Sequential fetch: reset for 1 cycle, then PCEn=1 with PCS=0 for 3 cycles -> PC = 0, 4, 8, 12; PCPlus8=20 when PC=12.
REQ-033 Branch redirect: PC=8, Branch=1, Result=32'h0000_0100, PCEn=1 -> next PC=32'h100; a further cycle with PCS=0 -> PC=32'h104.
REQ-034 Stall and reset: PCEn=0 with Branch=1 -> PC unchanged; then reset=1 with PCEn=1 and Branch=1 -> PC=RESET_PC at that edge.
REQ-035 Wrap-around: load Result=32'hFFFF_FFFC via Branch, then one cycle with PCS=0 -> PC=0.
